// File: rtl/sdram_master_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_master_arbiter
//
// Shares one Avalon-MM SDRAM controller slave between two masters:
//   port A - JTAG memory-mapped writer/reader
//   port B - read streamer feeding the playback RAM
// The grant is registered and fair: on a tie the master that was not granted
// last wins. A master keeps the slave for at most HOLD_MAX accepted commands
// while the other one is waiting. A command is never split: the grant cannot
// move while a command is stalled. Each accepted read pushes the issuing
// master's id into a tag FIFO. The returned readdatavalid pops the tag and is
// routed to that master.
//
// Ports
//   M100CLK, reset                 clock, asynchronous active-high reset
//   a_* / b_*  (in)                master address, byteenable, writedata, strobes
//   a_/b_waitrequest (out)         stall to each master
//   a_/b_readdatavalid (out)       routed read-data valid
//   m_readdata (out)               slave readdata, broadcast to both masters
//   s_* (out)                      command to the slave, all active-high
//   s_readdata, s_readdatavalid,
//   s_waitrequest (in)             response from the slave
//   grant (out)                    one-hot {B,A}, 00 = idle; this is the FSM state
//   pend_count (out)               outstanding reads
//   err_orphan (out)               sticky: readdatavalid with no tag queued
//
// Handshake: an Avalon command is held by its master while waitrequest=1.
// It is accepted on the cycle it is presented with waitrequest=0.
// ---------------------------------------------------------------------------
module sdram_master_arbiter #(
    parameter int ADDR_W   = 25,
    parameter int DATA_W   = 16,
    parameter int BE_W     = 2,
    parameter int MAX_PEND = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic                        M100CLK,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           a_address,
    input  logic [BE_W-1:0]             a_byteenable,
    input  logic [DATA_W-1:0]           a_writedata,
    input  logic                        a_write,
    input  logic                        a_read,
    output logic                        a_waitrequest,
    output logic                        a_readdatavalid,
    input  logic [ADDR_W-1:0]           b_address,
    input  logic [BE_W-1:0]             b_byteenable,
    input  logic [DATA_W-1:0]           b_writedata,
    input  logic                        b_write,
    input  logic                        b_read,
    output logic                        b_waitrequest,
    output logic                        b_readdatavalid,
    output logic [DATA_W-1:0]           m_readdata,
    output logic [ADDR_W-1:0]           s_address,
    output logic [BE_W-1:0]             s_byteenable,
    output logic [DATA_W-1:0]           s_writedata,
    output logic                        s_write,
    output logic                        s_read,
    output logic                        s_chipselect,
    input  logic [DATA_W-1:0]           s_readdata,
    input  logic                        s_readdatavalid,
    input  logic                        s_waitrequest,
    output logic [1:0]                  grant,
    output logic [$clog2(MAX_PEND):0]   pend_count,
    output logic                        err_orphan
);

    localparam int PTR_W  = $clog2(MAX_PEND);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0]  PEND_FULL = CNT_W'(MAX_PEND);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

    // The encoding is the one-hot grant itself.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GNT_A = 2'b01,
        ST_GNT_B = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic               last_b_q, last_b_d;   // 1: B was the most recent grant
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [PTR_W-1:0]   wr_q, rd_q;
    logic [CNT_W-1:0]   pend_q;
    logic               orphan_q;
    logic               tag_mem [MAX_PEND];   // 1 = read issued by B

    logic a_req, b_req, throttle, accept, push, pop, head_b;

    assign a_req    = a_read | a_write;
    assign b_req    = b_read | b_write;
    assign throttle = (pend_q == PEND_FULL);
    assign accept   = (s_read | s_write) & ~s_waitrequest;
    // s_read is already masked by the throttle, so a push can never hit a full FIFO.
    assign push     = s_read & ~s_waitrequest;
    assign pop      = s_readdatavalid & (pend_q != '0);
    assign head_b   = tag_mem[rd_q];

    assign grant           = state_q;
    assign pend_count      = pend_q;
    assign err_orphan      = orphan_q;
    assign m_readdata      = s_readdata;
    assign a_readdatavalid = pop & ~head_b;
    assign b_readdatavalid = pop & head_b;

    // ---- state register ----
    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            last_b_q <= 1'b1;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            hold_q   <= hold_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        hold_d   = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (a_req && b_req) state_d = last_b_q ? ST_GNT_A : ST_GNT_B;
                else if (a_req)     state_d = ST_GNT_A;
                else if (b_req)     state_d = ST_GNT_B;
            end
            ST_GNT_A: begin
                // A stalled command keeps a_req high, so the grant stays put.
                if (!a_req)                                        state_d = b_req ? ST_GNT_B : ST_IDLE;
                else if (accept && b_req && hold_q == HOLD_LAST)   state_d = ST_GNT_B;
            end
            ST_GNT_B: begin
                if (!b_req)                                        state_d = a_req ? ST_GNT_A : ST_IDLE;
                else if (accept && a_req && hold_q == HOLD_LAST)   state_d = ST_GNT_A;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q)                 hold_d = '0;
        else if (accept && hold_q != HOLD_LAST) hold_d = hold_q + HOLD_W'(1);

        if (state_d == ST_GNT_A)      last_b_d = 1'b0;
        else if (state_d == ST_GNT_B) last_b_d = 1'b1;
    end

    // ---- output logic: slave mux and waitrequests from the grant register ----
    always_comb begin
        s_address     = '0;
        s_byteenable  = '0;
        s_writedata   = '0;
        s_write       = 1'b0;
        s_read        = 1'b0;
        a_waitrequest = 1'b1;
        b_waitrequest = 1'b1;
        case (state_q)
            ST_GNT_A: begin
                s_address     = a_address;
                s_byteenable  = a_byteenable;
                s_writedata   = a_writedata;
                s_write       = a_write;
                s_read        = a_read & ~throttle;
                a_waitrequest = s_waitrequest | (a_read & throttle);
            end
            ST_GNT_B: begin
                s_address     = b_address;
                s_byteenable  = b_byteenable;
                s_writedata   = b_writedata;
                s_write       = b_write;
                s_read        = b_read & ~throttle;
                b_waitrequest = s_waitrequest | (b_read & throttle);
            end
            default: ;
        endcase
        s_chipselect = s_read | s_write;
    end

    // ---- tag FIFO pointers, occupancy, orphan flag ----
    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            wr_q     <= '0;
            rd_q     <= '0;
            pend_q   <= '0;
            orphan_q <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + PTR_W'(1);
            if (pop)  rd_q <= rd_q + PTR_W'(1);
            if (push && !pop)      pend_q <= pend_q + CNT_W'(1);
            else if (!push && pop) pend_q <= pend_q - CNT_W'(1);
            if (s_readdatavalid && pend_q == '0) orphan_q <= 1'b1;
        end
    end

    // The tag storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge M100CLK) begin
        if (push) tag_mem[wr_q] <= (state_q == ST_GNT_B);
    end

endmodule

// File: tb/tb_sdram_master_arbiter.sv
module tb_sdram_master_arbiter;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int BE_W   = 2;
    localparam logic [ADDR_W-1:0] B_ADDR = 25'h1AB;

    logic              M100CLK, reset;
    logic [ADDR_W-1:0] a_address, b_address, s_address;
    logic [BE_W-1:0]   a_byteenable, b_byteenable, s_byteenable;
    logic [DATA_W-1:0] a_writedata, b_writedata, s_writedata, m_readdata, s_readdata;
    logic              a_write, a_read, a_waitrequest, a_readdatavalid;
    logic              b_write, b_read, b_waitrequest, b_readdatavalid;
    logic              s_write, s_read, s_chipselect, s_readdatavalid, s_waitrequest;
    logic [1:0]        grant;
    logic [3:0]        pend_count;
    logic              err_orphan;

    int checks = 0;
    int failures = 0;

    sdram_master_arbiter dut (
        .M100CLK(M100CLK), .reset(reset),
        .a_address(a_address), .a_byteenable(a_byteenable), .a_writedata(a_writedata),
        .a_write(a_write), .a_read(a_read), .a_waitrequest(a_waitrequest),
        .a_readdatavalid(a_readdatavalid),
        .b_address(b_address), .b_byteenable(b_byteenable), .b_writedata(b_writedata),
        .b_write(b_write), .b_read(b_read), .b_waitrequest(b_waitrequest),
        .b_readdatavalid(b_readdatavalid),
        .m_readdata(m_readdata),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_write(s_write), .s_read(s_read), .s_chipselect(s_chipselect),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .s_waitrequest(s_waitrequest),
        .grant(grant), .pend_count(pend_count), .err_orphan(err_orphan)
    );

    // ---- clock ----
    initial M100CLK = 1'b0;
    always #5 M100CLK = ~M100CLK;

    // ---- vector table ----
    typedef struct {
        logic              ar, aw, br, rdv, sw;
        logic [ADDR_W-1:0] aaddr;
        logic [1:0]        grant;
        logic              sr, swr;
        logic [ADDR_W-1:0] saddr;
        logic              awt, bwt, ardv, brdv;
        logic [3:0]        pend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ar, aw, br, rdv, sw, input logic [ADDR_W-1:0] aaddr,
                                input logic [1:0] g, input logic sr, swr,
                                input logic [ADDR_W-1:0] saddr,
                                input logic awt, bwt, ardv, brdv, input logic [3:0] pend);
        vec_t v;
        v.ar = ar; v.aw = aw; v.br = br; v.rdv = rdv; v.sw = sw; v.aaddr = aaddr;
        v.grant = g; v.sr = sr; v.swr = swr; v.saddr = saddr;
        v.awt = awt; v.bwt = bwt; v.ardv = ardv; v.brdv = brdv; v.pend = pend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge M100CLK);
        #1;
    endtask

    task automatic idle_inputs();
        a_read = 0; a_write = 0; b_read = 0; b_write = 0;
        s_waitrequest = 0; s_readdatavalid = 0;
    endtask

    // ---- scoreboard for the alternation run: expected owner of each return ----
    logic [0:0] exp_q[$];   // 0 = A, 1 = B

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] pipe;
        logic       acc;
        logic       id;
        int         k;

        // Write burst of 4 from A, B idle.
        tbl.push_back(mk(0,1,0,0,0, 0, 2'b00,0,0, 0,      1,1,0,0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,1,0,0,0, ADDR_W'(i), 2'b01,0,1, ADDR_W'(i), 0,1,0,0, 0));
        tbl.push_back(mk(0,0,0,0,0, 0, 2'b01,0,0, 0,      0,1,0,0, 0));
        tbl.push_back(mk(0,0,0,0,0, 0, 2'b00,0,0, 0,      1,1,0,0, 0));
        // B reads while the slave withholds readdatavalid: throttle at 8.
        tbl.push_back(mk(0,0,1,0,0, 0, 2'b00,0,0, 0,      1,1,0,0, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0,0,1,0,0, 0, 2'b10,1,0, B_ADDR, 1,0,0,0, 4'(i)));
        tbl.push_back(mk(0,0,1,0,0, 0, 2'b10,0,0, B_ADDR, 1,1,0,0, 8));
        tbl.push_back(mk(0,0,1,0,0, 0, 2'b10,0,0, B_ADDR, 1,1,0,0, 8));
        tbl.push_back(mk(0,0,1,1,0, 0, 2'b10,0,0, B_ADDR, 1,1,0,1, 8)); // pop while throttled
        tbl.push_back(mk(0,0,1,0,0, 0, 2'b10,1,0, B_ADDR, 1,0,0,0, 7)); // reads resume
        tbl.push_back(mk(0,0,1,1,0, 0, 2'b10,0,0, B_ADDR, 1,1,0,1, 8));
        tbl.push_back(mk(0,0,1,1,0, 0, 2'b10,1,0, B_ADDR, 1,0,0,1, 7)); // push+pop
        tbl.push_back(mk(0,0,0,1,0, 0, 2'b10,0,0, B_ADDR, 1,0,0,1, 7));
        for (int i = 6; i >= 1; i--)
            tbl.push_back(mk(0,0,0,1,0, 0, 2'b00,0,0, 0, 1,1,0,1, 4'(i)));
        tbl.push_back(mk(0,0,0,0,0, 0, 2'b00,0,0, 0,      1,1,0,0, 0));
        // A's write stalled 5 cycles by the slave while B requests; A wins the tie.
        tbl.push_back(mk(0,1,1,0,1, 25'h55, 2'b00,0,0, 0, 1,1,0,0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,1,1,0,1, 25'h55, 2'b01,0,1, 25'h55, 1,1,0,0, 0));
        tbl.push_back(mk(0,1,1,0,0, 25'h55, 2'b01,0,1, 25'h55, 0,1,0,0, 0));
        tbl.push_back(mk(0,0,1,0,0, 25'h55, 2'b01,0,0, 25'h55, 0,1,0,0, 0));
        tbl.push_back(mk(0,0,1,0,0, 25'h55, 2'b10,1,0, B_ADDR, 1,0,0,0, 0));
        tbl.push_back(mk(0,0,0,0,0, 25'h55, 2'b10,0,0, B_ADDR, 1,0,0,0, 1));
        tbl.push_back(mk(0,0,0,1,0, 25'h55, 2'b00,0,0, 0,      1,1,0,1, 1));
        tbl.push_back(mk(0,0,0,0,0, 25'h55, 2'b00,0,0, 0,      1,1,0,0, 0));

        // ---- reset ----
        a_address = '0; b_address = B_ADDR;
        a_byteenable = 2'b11; b_byteenable = 2'b11;
        a_writedata = 16'hA5A5; b_writedata = 16'h5A5A; s_readdata = 16'h1234;
        idle_inputs();
        reset = 1;
        #12;
        chk("rst_grant", grant, 2'b00);
        chk("rst_pend", pend_count, 0);
        chk("rst_orphan", err_orphan, 0);
        chk("rst_s_cs", {s_read, s_write, s_chipselect}, 3'b000);
        chk("rst_wait", {a_waitrequest, b_waitrequest}, 2'b11);
        chk("rst_rdv", {a_readdatavalid, b_readdatavalid}, 2'b00);
        @(posedge M100CLK);
        #2 reset = 0;
        #1;
        next_cycle();

        // ---- table ----
        foreach (tbl[i]) begin
            a_read = tbl[i].ar; a_write = tbl[i].aw; b_read = tbl[i].br;
            s_readdatavalid = tbl[i].rdv; s_waitrequest = tbl[i].sw;
            a_address = tbl[i].aaddr;
            #1;
            chk($sformatf("v%0d_grant", i), grant, tbl[i].grant);
            chk($sformatf("v%0d_s_read", i), s_read, tbl[i].sr);
            chk($sformatf("v%0d_s_write", i), s_write, tbl[i].swr);
            chk($sformatf("v%0d_s_cs", i), s_chipselect, tbl[i].sr | tbl[i].swr);
            chk($sformatf("v%0d_s_addr", i), s_address, tbl[i].saddr);
            chk($sformatf("v%0d_a_wait", i), a_waitrequest, tbl[i].awt);
            chk($sformatf("v%0d_b_wait", i), b_waitrequest, tbl[i].bwt);
            chk($sformatf("v%0d_a_rdv", i), a_readdatavalid, tbl[i].ardv);
            chk($sformatf("v%0d_b_rdv", i), b_readdatavalid, tbl[i].brdv);
            chk($sformatf("v%0d_pend", i), pend_count, tbl[i].pend);
            next_cycle();
        end
        chk("tbl_orphan", err_orphan, 0);
        idle_inputs();

        // ---- both masters read continuously, 3-cycle slave latency ----
        pipe = '0;
        k = 0;
        a_read = 1; b_read = 1;
        for (int cyc = 0; cyc < 400 && (k < 64 || pipe != '0 || exp_q.size() != 0); cyc++) begin
            s_readdatavalid = pipe[2];
            #1;
            acc = s_read & ~s_waitrequest;
            if (acc) begin
                id = ((k / 16) % 2) == 1;
                chk($sformatf("alt_grant_k%0d", k), grant, id ? 2'b10 : 2'b01);
                exp_q.push_back(id);
                k++;
            end
            if (s_readdatavalid) begin
                if (exp_q.size() == 0) begin
                    chk("alt_unexpected_rdv", 1, 0);
                end else begin
                    id = exp_q.pop_front();
                    chk("alt_route", {a_readdatavalid, b_readdatavalid}, id ? 2'b01 : 2'b10);
                end
            end else begin
                chk("alt_no_rdv", {a_readdatavalid, b_readdatavalid}, 2'b00);
            end
            if (pend_count > 4'd8) chk("alt_pend_le_8", pend_count, 8);
            @(posedge M100CLK);
            #1;
            pipe = {pipe[1:0], acc};
            if (k >= 64) begin a_read = 0; b_read = 0; end
        end
        s_readdatavalid = 0;
        chk("alt_reads", k, 64);
        chk("alt_queue_empty", exp_q.size(), 0);
        #1;
        chk("alt_pend_end", pend_count, 0);
        next_cycle();
        next_cycle();
        chk("alt_grant_idle", grant, 2'b00);

        // ---- reset with 3 reads outstanding ----
        idle_inputs();
        b_read = 1;
        next_cycle();          // IDLE -> GNT_B
        next_cycle();
        next_cycle();
        next_cycle();          // three reads accepted
        b_read = 0;
        #1;
        chk("mid_pend3", pend_count, 3);
        reset = 1;
        #1;
        chk("mid_rst_grant", grant, 2'b00);
        chk("mid_rst_pend", pend_count, 0);
        chk("mid_rst_s_read", s_read, 0);
        chk("mid_rst_wait", {a_waitrequest, b_waitrequest}, 2'b11);
        next_cycle();
        reset = 0;
        next_cycle();
        chk("mid_orphan_clear", err_orphan, 0);
        s_readdatavalid = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mid_rdv%0d", i), {a_readdatavalid, b_readdatavalid}, 2'b00);
            chk($sformatf("mid_pend%0d", i), pend_count, 0);
            next_cycle();
        end
        s_readdatavalid = 0;
        #1;
        chk("mid_orphan_set", err_orphan, 1);
        chk("mid_pend_end", pend_count, 0);
        chk("mid_grant_end", grant, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
